result_writeback: RTL and testbench
===================================

Name: result_writeback

Overview:
- Receives completed results from N_PORT execution pipes (flow_p1 style RESULT + valid) and buffers them per port.
- Round-robin arbitrates onto the single regbank write port (write_address / write_data).
- Broadcasts a wakeup (physical register tag) to the scheduler in the same cycle as the regbank write.
- Closes the result path from execute back to the physical register file.

Parameters:
- N_PORT, 2, number of execution result ports.
- DEPTH, 4, per-port FIFO entries; power of 2, ≥2.
- AWIDTH, 7, physical register address width (128 physical registers).
- DWIDTH, 32, data width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- result_i  in  N_PORT x RESULT  per-port result; uses fields rd[AWIDTH-1:0] and data[DWIDTH-1:0].
- result_valid_i  in  N_PORT  per-port result valid.
- result_ready_o  out  N_PORT  per-port accept; high when that port's FIFO is not full.
- write_valid  out  1  regbank write enable.
- write_address  out  AWIDTH  regbank write address.
- write_data  out  DWIDTH  regbank write data.
- wakeup_valid  out  1  scheduler wakeup strobe; equals write_valid.
- wakeup_reg  out  AWIDTH  register made valid; equals write_address.
- occupancy  out  N_PORT x (log2(DEPTH)+1)  per-port FIFO fill level.

Behaviour:
- Reset is asynchronous and active-high. It clears:
  - all FIFOs, occupancy = 0;
  - rr_ptr = 0;
  - write_valid = 0, wakeup_valid = 0;
  - write_address, write_data and wakeup_reg = 0.
- Reset asserted mid-operation discards all buffered results. No write is issued in the cycle after reset deasserts.
- Push: on a rising clk with result_valid_i[i] & result_ready_o[i], the entry is appended to FIFO i.
  - result_ready_o[i] = (occupancy[i] != DEPTH), registered-state only.
  - There is no same-cycle pass-through when the FIFO is full, even if it pops that cycle.
- Arbitration runs each cycle over ports with a non-empty FIFO.
  - Search order is rr_ptr, rr_ptr+1, … mod N_PORT. The first non-empty port wins.
  - The winner pops its head entry.
  - rr_ptr <= (winner+1) mod N_PORT. rr_ptr is unchanged when no port is non-empty.
- Output stage is registered, so latency is push → write_valid = 2 cycles when buffer-empty and uncontended:
  - cycle N: push;
  - N+1: head visible, arbitrated, popped;
  - output registered at the end of N+1, so write_valid is high in cycle N+2.
- Popped entry with rd == 0 (p0 is hardwired zero):
  - the entry is consumed;
  - write_valid = 0 that cycle;
  - write_address and write_data hold their previous values.
- Popped entry with rd != 0: write_valid = 1, write_address = rd, write_data = data, for exactly one cycle.
- No port is non-empty: write_valid = 0.
- At most one write per cycle. Throughput is 1 result/cycle total. Each port is guaranteed ≥1 pop every N_PORT cycles while non-empty.
- Simultaneous push and pop on the same FIFO in one cycle: occupancy is unchanged and ordering is preserved.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap naturally. Full/empty is derived from occupancy.
- Two ports holding the same rd is not an error. Both are written in arbitration order (rename guarantees it does not occur in normal flow).

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - An arbitration-eligible port whose FIFO is empty and which presents result_valid_i this cycle may win directly. In that case the entry does not enter the FIFO.
  - Latency push → write_valid becomes 1 cycle.
  - FIFO entries of any port take priority over bypass candidates. Among bypass candidates the round-robin order applies.
- Undefined: behaviour exactly as above, 2-cycle latency.

Test Plan:
- Reset then a single push on port 0 (rd=5, data=0xDEADBEEF) → write_valid=1, write_address=5, write_data=0xDEADBEEF, wakeup_reg=5 in cycle N+2 (N+1 with WB_BYPASS_EN). One-cycle pulse only.
- Both ports push every cycle for 8 cycles (port0 rd=10..17, port1 rd=20..27) → writes alternate 10, 20, 11, 21, … All 16 are written with none dropped. result_ready_o deasserts when occupancy hits 4 and re-asserts after a pop.
- Port 1 fills to DEPTH=4 while port 0 is idle, with result_valid_i held high → result_ready_o[1]=0 in the cycle occupancy[1]=4. The 5th entry is not accepted until a pop. FIFO order is preserved.
- Push rd=0 data=0x1234 followed by rd=3 data=0x55 → no write for rd=0, then write_address=3 with write_data=0x55. write_address does not hold 0 during the rd=0 pop.
- Assert reset while both FIFOs hold 3 entries → occupancy=0 and write_valid=0 immediately (asynchronously). After deassert no stale writes appear.
- Pointer wrap: stream 20 results through port 0 with intermittent port-1 traffic → every rd/data is written exactly once and in per-port order.

Source files
------------

// File: rtl/result_writeback.sv
// -----------------------------------------------------------------------------
// result_writeback
//
// Purpose:
//   Collects completed results from N_PORT execution pipes into small per-port
//   FIFOs and drains them, one per cycle, onto the single regbank write port
//   using a round-robin arbiter. The scheduler wakeup (physical register tag)
//   is broadcast in the same cycle as the regbank write.
//
// Optional feature (macro WB_BYPASS_EN):
//   When defined, a port whose FIFO is empty and which presents a valid
//   result may win arbitration directly. The entry then skips the FIFO and
//   push->write latency drops from 2 to 1 cycle. Any non-empty FIFO still
//   outranks every bypass candidate. When undefined the design is the plain
//   2-cycle buffered path.
//
// Ports:
//   clk            in   clock
//   reset          in   asynchronous, active-high reset
//   result_i       in   [N_PORT][AWIDTH+DWIDTH] per-port result, packed {rd, data}
//   result_valid_i in   [N_PORT] per-port result valid
//   result_ready_o out  [N_PORT] per-port accept (FIFO not full, state only)
//   write_valid    out  regbank write enable
//   write_address  out  [AWIDTH] regbank write address
//   write_data     out  [DWIDTH] regbank write data
//   wakeup_valid   out  scheduler wakeup strobe (same as write_valid)
//   wakeup_reg     out  [AWIDTH] woken register tag (same as write_address)
//   occupancy      out  [N_PORT][log2(DEPTH)+1] per-port FIFO fill level
// -----------------------------------------------------------------------------
module result_writeback #(
  parameter int N_PORT = 2,
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 7,
  parameter int DWIDTH = 32
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [N_PORT-1:0][AWIDTH+DWIDTH-1:0]      result_i,
  input  logic [N_PORT-1:0]                         result_valid_i,
  output logic [N_PORT-1:0]                         result_ready_o,
  output logic                                      write_valid,
  output logic [AWIDTH-1:0]                         write_address,
  output logic [DWIDTH-1:0]                         write_data,
  output logic                                      wakeup_valid,
  output logic [AWIDTH-1:0]                         wakeup_reg,
  output logic [N_PORT-1:0][$clog2(DEPTH):0]        occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int SEL_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;
  localparam int EW    = AWIDTH + DWIDTH;
  localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);

  // Per-port status and handshakes
  logic [N_PORT-1:0]         w_nonempty;
  logic [N_PORT-1:0]         w_push;
  logic [N_PORT-1:0]         w_fifo_sel;
  logic [N_PORT-1:0]         w_bypass_sel;
  logic [N_PORT-1:0][EW-1:0] w_head;

  // Arbitration result
  logic                      w_any;
  logic                      w_bypass_hit;
  logic [SEL_W-1:0]          w_win;
  logic [SEL_W-1:0]          w_rr_next;
  logic [EW-1:0]             w_sel_entry;
  logic [AWIDTH-1:0]         w_sel_rd;
  logic [DWIDTH-1:0]         w_sel_data;
  logic                      w_do_write;

  // Output stage and arbiter state
  logic [SEL_W-1:0]          r_rr_ptr;
  logic                      r_write_valid;
  logic [AWIDTH-1:0]         r_write_address;
  logic [DWIDTH-1:0]         r_write_data;

  // ---------------------------------------------------------------------------
  // Per-port FIFOs
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_PORT; gi++) begin : g_port
      logic [PTR_W-1:0] r_wptr;
      logic [PTR_W-1:0] r_rptr;
      logic [OCC_W-1:0] r_occ;
      logic [EW-1:0]    r_mem [DEPTH];
      logic             w_pop;

      assign w_head[gi]         = r_mem[r_rptr];
      assign occupancy[gi]      = r_occ;
      assign w_nonempty[gi]     = (r_occ != '0);
      // Ready looks only at stored state: a full FIFO refuses even when it
      // is about to pop, which keeps ready off the arbitration path.
      assign result_ready_o[gi] = (r_occ != FULL_LVL);

      assign w_fifo_sel[gi]   = w_any & ~w_bypass_hit & (w_win == SEL_W'(gi));
      assign w_bypass_sel[gi] = w_any &  w_bypass_hit & (w_win == SEL_W'(gi));
      assign w_pop            = w_fifo_sel[gi];
      // A bypassed entry is consumed directly and must not also be stored.
      assign w_push[gi] = result_valid_i[gi] & result_ready_o[gi] & ~w_bypass_sel[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_occ  <= '0;
        end else begin
          if (w_push[gi]) r_wptr <= r_wptr + 1'b1;
          if (w_pop)      r_rptr <= r_rptr + 1'b1;
          case ({w_push[gi], w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
          endcase
        end
      end

      // Storage needs no reset; occupancy alone decides what is valid.
      always_ff @(posedge clk) begin
        if (w_push[gi]) r_mem[r_wptr] <= result_i[gi];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: FIFO heads first, then (optionally) bypass candidates,
  // each pass searching from r_rr_ptr upwards modulo N_PORT.
  // ---------------------------------------------------------------------------
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] w_idx;
    idx          = 0;
    w_idx        = '0;
    w_any        = 1'b0;
    w_bypass_hit = 1'b0;
    w_win        = '0;
    for (int k = 0; k < N_PORT; k++) begin
      idx   = (int'(r_rr_ptr) + k) % N_PORT;
      w_idx = SEL_W'(idx);
      if (!w_any && w_nonempty[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
`ifdef WB_BYPASS_EN
    for (int k = 0; k < N_PORT; k++) begin
      idx   = (int'(r_rr_ptr) + k) % N_PORT;
      w_idx = SEL_W'(idx);
      if (!w_any && !w_nonempty[w_idx] && result_valid_i[w_idx]) begin
        w_any        = 1'b1;
        w_bypass_hit = 1'b1;
        w_win        = w_idx;
      end
    end
`endif
  end

  assign w_rr_next   = SEL_W'((int'(w_win) + 1) % N_PORT);
  assign w_sel_entry = w_bypass_hit ? result_i[w_win] : w_head[w_win];
  assign w_sel_rd    = w_sel_entry[EW-1:DWIDTH];
  assign w_sel_data  = w_sel_entry[DWIDTH-1:0];
  // p0 is hardwired zero: such results are drained but never written.
  assign w_do_write  = w_any && (w_sel_rd != '0);

  // ---------------------------------------------------------------------------
  // Registered write / wakeup stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr        <= '0;
      r_write_valid   <= 1'b0;
      r_write_address <= '0;
      r_write_data    <= '0;
    end else begin
      r_write_valid <= w_do_write;
      // Address/data hold their last written values on idle or p0 cycles.
      if (w_do_write) begin
        r_write_address <= w_sel_rd;
        r_write_data    <= w_sel_data;
      end
      if (w_any) r_rr_ptr <= w_rr_next;
    end
  end

  assign write_valid   = r_write_valid;
  assign write_address = r_write_address;
  assign write_data    = r_write_data;
  assign wakeup_valid  = r_write_valid;
  assign wakeup_reg    = r_write_address;

endmodule

// File: tb/tb_result_writeback.sv
// -----------------------------------------------------------------------------
// tb_result_writeback
//
// Self-checking bench for result_writeback (N_PORT=2, DEPTH=4, AWIDTH=7,
// DWIDTH=32). Accepted results with rd != 0 are pushed to a per-port
// expected queue; every regbank write is matched against the head of the
// queue whose rd it carries, which enforces per-port ordering and catches
// dropped, duplicated or spurious writes. Directed checks cover latency,
// reset, p0 handling, arbitration order and FIFO-full behaviour.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_result_writeback;

  localparam int N_PORT = 2;
  localparam int DEPTH  = 4;
  localparam int AW     = 7;
  localparam int DW     = 32;
  localparam int EW     = AW + DW;
  localparam int OW     = $clog2(DEPTH) + 1;
`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic                         clk;
  logic                         reset;
  logic [N_PORT-1:0][EW-1:0]    result_i;
  logic [N_PORT-1:0]            result_valid_i;
  logic [N_PORT-1:0]            result_ready_o;
  logic                         write_valid;
  logic [AW-1:0]                write_address;
  logic [DW-1:0]                write_data;
  logic                         wakeup_valid;
  logic [AW-1:0]                wakeup_reg;
  logic [N_PORT-1:0][OW-1:0]    occupancy;

  result_writeback #(
    .N_PORT(N_PORT), .DEPTH(DEPTH), .AWIDTH(AW), .DWIDTH(DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .result_i       (result_i),
    .result_valid_i (result_valid_i),
    .result_ready_o (result_ready_o),
    .write_valid    (write_valid),
    .write_address  (write_address),
    .write_data     (write_data),
    .wakeup_valid   (wakeup_valid),
    .wakeup_reg     (wakeup_reg),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [EW-1:0] q0[$];
  logic [EW-1:0] q1[$];
  logic [AW-1:0] wr_log[$];
  logic [1:0]    saw_full;
  logic [EW-1:0] mon_head;
  logic          mon_match;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    return {rd, d};
  endfunction

  // Scoreboard: every write must match the head of one port's queue.
  always @(negedge clk) begin
    if (reset === 1'b0 && write_valid === 1'b1) begin
      wr_log.push_back(write_address);
      mon_match = 1'b0;
      mon_head  = '0;
      if (q0.size() > 0 && q0[0][EW-1:DW] == write_address) begin
        mon_head  = q0.pop_front();
        mon_match = 1'b1;
      end else if (q1.size() > 0 && q1[0][EW-1:DW] == write_address) begin
        mon_head  = q1.pop_front();
        mon_match = 1'b1;
      end
      if (mon_match) begin
        $display("WRITE addr=%0d data=0x%08h wakeup=%0d", write_address, write_data, wakeup_reg);
        check_eq("sb_data", 64'(write_data), 64'(mon_head[DW-1:0]));
        check_eq("sb_wakeup_reg", 64'(wakeup_reg), 64'(mon_head[EW-1:DW]));
        check_eq("sb_wakeup_valid", 64'(wakeup_valid), 64'd1);
      end else begin
        $display("WRITE addr=%0d data=0x%08h (no matching expected entry)", write_address, write_data);
        check_eq("sb_unexpected_write", 64'(write_valid), 64'd0);
      end
    end
  end

  // One clock: sample acceptance before the edge, advance, record accepted
  // entries in the scoreboard. Returns at posedge+1.
  task automatic tick(output logic a0, output logic a1);
    logic c0, c1;
    @(negedge clk);
    c0 = result_valid_i[0] & result_ready_o[0];
    c1 = result_valid_i[1] & result_ready_o[1];
    check_eq("ready_vs_occ0", 64'(result_ready_o[0]), 64'(occupancy[0] != OW'(DEPTH)));
    check_eq("ready_vs_occ1", 64'(result_ready_o[1]), 64'(occupancy[1] != OW'(DEPTH)));
    if (occupancy[0] == OW'(DEPTH)) saw_full[0] = 1'b1;
    if (occupancy[1] == OW'(DEPTH)) saw_full[1] = 1'b1;
    @(posedge clk);
    #1;
    if (c0 && result_i[0][EW-1:DW] != '0) q0.push_back(result_i[0]);
    if (c1 && result_i[1][EW-1:DW] != '0) q1.push_back(result_i[1]);
    a0 = c0;
    a1 = c1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    result_valid_i = '0;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_reset_no_write", 64'(write_valid), 64'd0);
  endtask

  task automatic drain();
    logic a0, a1;
    result_valid_i = '0;
    for (int c = 0; c < 60; c++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      tick(a0, a1);
    end
    check_eq("drain_q0_empty", 64'(q0.size()), 64'd0);
    check_eq("drain_q1_empty", 64'(q1.size()), 64'd0);
    tick(a0, a1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic a0, a1;
    int   i0, i1, j;

    reset          = 1'b1;
    result_valid_i = '0;
    result_i       = '0;
    saw_full       = '0;

    // ---- reset state ----
    do_reset();
    check_eq("rst_write_valid", 64'(write_valid), 64'd0);
    check_eq("rst_write_address", 64'(write_address), 64'd0);
    check_eq("rst_write_data", 64'(write_data), 64'd0);
    check_eq("rst_wakeup_valid", 64'(wakeup_valid), 64'd0);
    check_eq("rst_wakeup_reg", 64'(wakeup_reg), 64'd0);
    check_eq("rst_occ0", 64'(occupancy[0]), 64'd0);
    check_eq("rst_occ1", 64'(occupancy[1]), 64'd0);
    check_eq("rst_ready", 64'(result_ready_o), 64'd3);

    // ---- single push, latency and one-cycle pulse ----
    result_i[0]    = mk(AW'(5), 32'hDEADBEEF);
    result_valid_i = 2'b01;
    tick(a0, a1);
    check_eq("t1_accept", 64'(a0), 64'd1);
    result_valid_i = '0;
    for (int k = 1; k <= 3; k++) begin
      check_eq("t1_write_valid", 64'(write_valid), 64'(k == LAT));
      if (k == LAT) begin
        check_eq("t1_write_address", 64'(write_address), 64'd5);
        check_eq("t1_write_data", 64'(write_data), 64'hDEADBEEF);
        check_eq("t1_wakeup_reg", 64'(wakeup_reg), 64'd5);
        check_eq("t1_wakeup_valid", 64'(wakeup_valid), 64'd1);
      end
      tick(a0, a1);
    end

    // ---- both ports streaming: alternation, back-pressure, no drops ----
    do_reset();
    wr_log.delete();
    saw_full = '0;
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 40 && (i0 < 8 || i1 < 8); c++) begin
      result_valid_i[0] = (i0 < 8);
      result_i[0]       = mk(AW'(10 + i0), 32'hC0DE0000 + 32'(10 + i0));
      result_valid_i[1] = (i1 < 8);
      result_i[1]       = mk(AW'(20 + i1), 32'hBEEF0000 + 32'(20 + i1));
      tick(a0, a1);
      if (a0) i0++;
      if (a1) i1++;
    end
    check_eq("t2_all_accepted", 64'(i0 + i1), 64'd16);
    drain();
    check_eq("t2_port0_reached_full", 64'(saw_full[0]), 64'd1);
    check_eq("t2_port1_reached_full", 64'(saw_full[1]), 64'd1);
    check_eq("t2_write_count", 64'(wr_log.size()), 64'd16);
    for (int i = 0; i < wr_log.size() && i < 16; i++)
      check_eq("t2_rr_order", 64'(wr_log[i]), 64'((i % 2 == 0) ? (10 + i / 2) : (20 + i / 2)));

    // ---- rd=0 consumed silently, address/data hold ----
    result_i[0]    = mk(AW'(0), 32'h00001234);
    result_valid_i = 2'b01;
    tick(a0, a1);
    check_eq("t4_accept_p0", 64'(a0), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      if (k == 1) begin
        result_i[0]    = mk(AW'(3), 32'h00000055);
        result_valid_i = 2'b01;
      end else begin
        result_valid_i = '0;
      end
      if (k == LAT) begin
        check_eq("t4_p0_no_write", 64'(write_valid), 64'd0);
        check_eq("t4_addr_hold", 64'(write_address), 64'd27);
        check_eq("t4_data_hold", 64'(write_data), 64'hBEEF001B);
      end
      if (k == LAT + 1) begin
        check_eq("t4_rd3_valid", 64'(write_valid), 64'd1);
        check_eq("t4_rd3_address", 64'(write_address), 64'd3);
        check_eq("t4_rd3_data", 64'(write_data), 64'h55);
      end
      tick(a0, a1);
    end
    drain();

    // ---- asynchronous reset with buffered entries ----
    for (int c = 0; c < 10; c++) begin
      if (occupancy[0] >= 3 && occupancy[1] >= 3) break;
      result_valid_i = 2'b11;
      result_i[0]    = mk(AW'(60 + c), 32'h11110000 + 32'(c));
      result_i[1]    = mk(AW'(80 + c), 32'h22220000 + 32'(c));
      tick(a0, a1);
    end
    result_valid_i = '0;
    check_eq("t5_fill_reached", 64'(occupancy[0] >= 3 && occupancy[1] >= 3), 64'd1);
    #2;
    reset = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check_eq("t5_async_occ0", 64'(occupancy[0]), 64'd0);
    check_eq("t5_async_occ1", 64'(occupancy[1]), 64'd0);
    check_eq("t5_async_write_valid", 64'(write_valid), 64'd0);
    check_eq("t5_async_wakeup_valid", 64'(wakeup_valid), 64'd0);
    check_eq("t5_async_write_address", 64'(write_address), 64'd0);
    check_eq("t5_async_wakeup_reg", 64'(wakeup_reg), 64'd0);
    check_eq("t5_async_ready", 64'(result_ready_o), 64'd3);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(a0, a1);
      check_eq("t5_no_stale_write", 64'(write_valid), 64'd0);
    end

    // ---- pointer wrap: 20 on port 0, intermittent port 1 ----
    i0 = 0;
    j  = 0;
    for (int c = 0; c < 120 && (i0 < 20 || j < 6); c++) begin
      result_valid_i[0] = (i0 < 20);
      result_i[0]       = mk(AW'(40 + i0), 32'h0A000000 + 32'(i0));
      result_valid_i[1] = (j < 6) && (c % 3 != 2);
      result_i[1]       = mk(AW'(100 + j), 32'h0B000000 + 32'(j));
      tick(a0, a1);
      if (a0) i0++;
      if (a1) j++;
    end
    check_eq("t6_port0_count", 64'(i0), 64'd20);
    check_eq("t6_port1_count", 64'(j), 64'd6);
    drain();
    check_eq("t6_final_occ0", 64'(occupancy[0]), 64'd0);
    check_eq("t6_final_occ1", 64'(occupancy[1]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
